// File: rtl/stim_seq.sv
// stim_seq: button-press stimulus sequencer for a device under test.
// Holds the target in reset, then plays one press/gap command at a time until the run budget expires.
module stim_seq #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_HOLD   = 4,
    parameter int unsigned RUN_CYCLES = 1200,
    // Widening the channel port lets a bench offer out-of-range indices.
    parameter int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CHAN_W-1:0]   cmd_chan,
    input  logic [CNT_W-1:0]    cmd_len,
    input  logic [CNT_W-1:0]    cmd_gap,
    output logic                tgt_rst_n,
    output logic [CHANNELS-1:0] btn_n,
    output logic                busy,
    output logic                err,
    output logic                done
);

    localparam int unsigned        RUN_W     = CNT_W + 8;
    localparam int unsigned        HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [RUN_W-1:0]   RUN_LIM   = RUN_W'(RUN_CYCLES);

    typedef enum logic [2:0] {
        StRsth,
        StIdle,
        StPress,
        StGap,
        StDone
    } state_e;

    state_e              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [CNT_W-1:0]    r_timer;
    logic [CNT_W-1:0]    r_gap;
    logic [CHAN_W-1:0]   r_chan;
    logic [RUN_W-1:0]    r_run;
    logic                r_busy;
    logic                r_err;

    state_e              w_state_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [CNT_W-1:0]    w_timer_nxt;
    logic [CNT_W-1:0]    w_gap_nxt;
    logic [CHAN_W-1:0]   w_chan_nxt;
    logic [RUN_W-1:0]    w_run_nxt;
    logic                w_err_nxt;
    logic                w_running;
    logic                w_run_hit;
    logic                w_chan_ok;
    logic [CNT_W-1:0]    w_len_eff;

    assign w_running = (r_state == StIdle) || (r_state == StPress) || (r_state == StGap);
    // The run budget expires on the edge where the counter would step onto RUN_CYCLES.
    assign w_run_hit = (RUN_CYCLES != 0) && w_running && ((r_run + RUN_W'(1)) == RUN_LIM);
    assign w_chan_ok = (32'(cmd_chan) < CHANNELS);
    assign w_len_eff = (cmd_len == '0) ? CNT_W'(1) : cmd_len;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_timer_nxt = r_timer;
        w_gap_nxt   = r_gap;
        w_chan_nxt  = r_chan;
        w_err_nxt   = 1'b0;
        w_run_nxt   = r_run;

        if (w_running && (r_run != '1)) begin
            w_run_nxt = r_run + RUN_W'(1);
        end

        unique case (r_state)
            StRsth: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = StIdle;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            StIdle: begin
                if (w_run_hit) begin
                    w_state_nxt = StDone;
                end else if (cmd_valid) begin
                    w_gap_nxt  = cmd_gap;
                    w_chan_nxt = cmd_chan;
                    if (w_chan_ok) begin
                        w_state_nxt = StPress;
                        w_timer_nxt = w_len_eff;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_timer_nxt = cmd_gap;
                        w_state_nxt = (cmd_gap == '0) ? StIdle : StGap;
                    end
                end
            end
            StPress: begin
                if (w_run_hit) begin
                    w_state_nxt = StDone;
                end else if (r_timer == CNT_W'(1)) begin
                    w_timer_nxt = r_gap;
                    w_state_nxt = (r_gap == '0) ? StIdle : StGap;
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            StGap: begin
                if (w_run_hit) begin
                    w_state_nxt = StDone;
                end else if (r_timer == CNT_W'(1)) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            StDone: begin
                w_state_nxt = StDone;
            end
            default: begin
                w_state_nxt = StRsth;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRsth;
            r_hold  <= '0;
            r_timer <= '0;
            r_gap   <= '0;
            r_chan  <= '0;
            r_run   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_timer <= w_timer_nxt;
            r_gap   <= w_gap_nxt;
            r_chan  <= w_chan_nxt;
            r_run   <= w_run_nxt;
            r_busy  <= (w_state_nxt == StPress) || (w_state_nxt == StGap);
            r_err   <= w_err_nxt;
        end
    end

    assign cmd_ready = (r_state == StIdle);
    assign tgt_rst_n = (r_state != StRsth);
    assign done      = (r_state == StDone);
    assign busy      = r_busy;
    assign err       = r_err;

    // Only a valid channel ever reaches StPress, so at most one button is low.
    always_comb begin
        btn_n = '1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if ((r_state == StPress) && (r_chan == CHAN_W'(i))) begin
                btn_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: doc/stim_seq.md
STIM_SEQ -- requirements
Module: stim_seq

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of active-low button outputs, 1..32.
REQ-002 SHALL have parameter CNT_W, default 16: width of press/gap duration fields and internal timers.
REQ-003 SHALL have parameter RST_HOLD, default 4: cycles tgt_rst_n is held low after rst, minimum 1.
REQ-004 SHALL have parameter RUN_CYCLES, default 1200: cycles after tgt_rst_n release until done asserts; 0 disables done.
REQ-005 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1: command offered.
REQ-008 SHALL have port cmd_ready  output  1: command accepted when cmd_valid and cmd_ready are both high on an edge.
REQ-009 SHALL have port cmd_chan  input  $clog2(CHANNELS) or 1 (whichever is larger): button index.
REQ-010 SHALL have port cmd_len  input  CNT_W: press duration in cycles.
REQ-011 SHALL have port cmd_gap  input  CNT_W: release duration in cycles after the press.
REQ-012 SHALL have port tgt_rst_n  output  1: active-low reset to the device under test.
REQ-013 SHALL have port btn_n  output  CHANNELS: active-low buttons, 1 = released.
REQ-014 SHALL have port busy  output  1: high in PRESS or GAP.
REQ-015 SHALL have port err  output  1: one-cycle pulse on rejected command.
REQ-016 SHALL have port done  output  1: sticky end-of-run flag.

Function
REQ-017 SHALL implement states RSTH, IDLE, PRESS, GAP, DONE.
REQ-018 RSTH: tgt_rst_n=0; SHALL go to IDLE after exactly RST_HOLD cycles in RSTH.
REQ-019 In IDLE, cmd_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-020 On acceptance with cmd_chan < CHANNELS: btn_n[cmd_chan] SHALL be 0 from the next cycle; state goes to PRESS.
REQ-021 The press SHALL last max(cmd_len,1) cycles; cmd_len=0 SHALL be treated as 1.
REQ-022 After the press: btn_n all 1; state goes to GAP for cmd_gap cycles (0 = straight back to IDLE), then IDLE.
REQ-023 Command values SHALL be latched at acceptance; changes to the cmd_* inputs afterwards SHALL have no effect.
REQ-024 On acceptance with cmd_chan >= CHANNELS: no press; err pulses 1 cycle; state goes to GAP, honouring cmd_gap.
REQ-025 Only one btn_n bit SHALL ever be 0 at a time.
REQ-026 A run counter (CNT_W+8 bits, saturating) SHALL start at tgt_rst_n release; when it reaches RUN_CYCLES (nonzero), state SHALL go to DONE.
REQ-027 Reaching RUN_CYCLES in PRESS or GAP SHALL abort the command: btn_n all 1 the next cycle, state DONE.
REQ-028 If RUN_CYCLES is reached in the same cycle as an acceptance, the acceptance SHALL be ignored: no press, no err.
REQ-029 DONE: done=1, cmd_ready=0, btn_n all 1, tgt_rst_n=1; the block SHALL stay in DONE until rst.
REQ-030 busy SHALL be a registered decode of the state, with no combinational path from the inputs.

Reset
REQ-031 While rst=1: state RSTH, tgt_rst_n=0, btn_n all 1, cmd_ready=0, busy=0, err=0, done=0, and all timers cleared.
REQ-032 rst asserted mid-operation (PRESS, GAP or DONE) SHALL release every button the next cycle and restart the RST_HOLD sequence.

Verification
REQ-033 Reset sequencing (RST_HOLD=4): deassert rst -> tgt_rst_n low for exactly 4 cycles, then high; cmd_ready rises in the same cycle.
REQ-034 Nominal press (chan=2, len=5, gap=3): accept -> btn_n=8'hFB for 5 cycles, then 8'hFF with busy for 3 cycles, then cmd_ready=1.
REQ-035 Zero-length edge case (len=0, gap=0): exactly one cycle of press, then cmd_ready back the following cycle.
REQ-036 Invalid channel (CHANNELS=8, chan=9 with a 4-bit override bench, gap=2): err 1-cycle pulse, btn_n stays 8'hFF, busy for 2 cycles.
REQ-037 Run timeout (RUN_CYCLES=20, len=100): done=1 at cycle 20 after release, the button is released the next cycle, further cmd_valid is ignored.
REQ-038 Reset mid-press: rst high during PRESS -> btn_n=8'hFF and tgt_rst_n=0 the next cycle; the sequence then repeats as in REQ-033.
